dmi_jtag_ctrl: RTL and testbench
================================

DMI_JTAG_CTRL -- requirements
Module: dmi_jtag_ctrl

Interface
REQ-001 SHALL have parameter IdleCycles, default 3'd1: value reported in dtmcs.idle.
REQ-002 SHALL have parameter AbitsW, default 7: DMI address width; DMI DR length = AbitsW+34.
REQ-003 SHALL have ports: tck_i in 1 clock (JTAG TCK); trst_i in 1 asynchronous active-high reset.
REQ-004 SHALL have TAP-side ports: capture_i, shift_i, update_i, tdi_i, dmi_clear_i, dtmcs_select_i, dmi_select_i in 1 each; dtmcs_tdo_o, dmi_tdo_o out 1 each.
REQ-005 SHALL have request ports: dmi_req_valid_o out 1; dmi_req_ready_i in 1; dmi_req_addr_o out AbitsW; dmi_req_data_o out 32; dmi_req_op_o out 2 (1 read, 2 write).
REQ-006 SHALL have response ports: dmi_resp_valid_i in 1; dmi_resp_ready_o out 1; dmi_resp_data_i in 32; dmi_resp_resp_i in 2.

Function
REQ-007 SHALL hold a 32-bit dtmcs shift register: capture loads {14'b0, dmihardreset=0, dmireset=0, 1'b0, idle=IdleCycles, dmistat=error_q, abits=AbitsW, version=4'd1}; shift moves right with tdi_i into bit 31; dtmcs_tdo_o = bit 0.
REQ-008 SHALL, on update_i with dtmcs_select_i: bit16 set clears error_q; bit17 set returns FSM to Idle, clears error_q, drops dmi_req_valid_o.
REQ-009 SHALL hold a DMI shift register {addr, data[31:0], op[1:0]}: shifts right with tdi_i into MSB when shift_i and dmi_select_i; dmi_tdo_o = bit 0.
REQ-010 SHALL, on capture_i with dmi_select_i: load {addr_q, data_q, 2'd3} if FSM not Idle or error_q busy; else {addr_q, data_q, error_q}.
REQ-011 SHALL set sticky error_q = 2'd3 (busy) on DMI capture or DMI update while FSM not Idle.
REQ-012 SHALL use FSM states Idle, Read, WaitReadValid, Write, WaitWriteValid.
REQ-013 SHALL, in Idle on DMI update with error_q = 0: op 1 -> latch addr, go Read; op 2 -> latch addr, data, go Write; op 0/3 -> stay Idle.
REQ-014 SHALL assert dmi_req_valid_o in Read/Write only; on dmi_req_ready_i go WaitReadValid/WaitWriteValid next cycle.
REQ-015 SHALL tie dmi_resp_ready_o = 1.
REQ-016 SHALL, in WaitReadValid on dmi_resp_valid_i: data_q <= dmi_resp_data_i, error_q <= dmi_resp_resp_i if nonzero, go Idle; WaitWriteValid same but data_q unchanged.
REQ-017 SHALL drive dmi_req_addr_o/data_o/op_o from latched registers, stable while dmi_req_valid_o high.
REQ-018 SHALL, on dmi_clear_i (any state): go Idle, clear error_q, drop dmi_req_valid_o next cycle.
REQ-019 SHALL give dmi_clear_i/dmihardreset priority over same-cycle response or update.
REQ-020 SHALL, on same-cycle response and DMI capture, treat FSM as non-Idle (registered state) -> capture busy.

Reset
REQ-021 SHALL on trst_i: FSM Idle, error_q 0, addr_q/data_q 0, shift registers 0, dmi_req_valid_o 0, tdo outputs 0.
REQ-022 SHALL abandon any outstanding request on reset mid-transaction; late responses ignored in Idle.

Structure
REQ-023 SHALL place dmi_req/dmi_resp field widths, op encodings (Nop 0, Read 1, Write 2, Busy 3), dtmcs bit positions and the FSM state enum in shared package dm_pkg.
REQ-024 SHALL be one module; an optional sub-module dmi_shift_reg (generic width shift/capture register) is natural.

Verification
REQ-025 SHALL cover: dtmcs capture+32 shifts, IdleCycles 1 -> TDO stream 0x00001071.
REQ-026 SHALL cover: DMI write addr 0x10 data 0xDEADBEEF op 2, ready 1 cycle later -> one req_valid pulse with those fields, Idle after resp 0.
REQ-027 SHALL cover: DMI read addr 0x04, resp data 0x12345678 resp 0 -> next DMI capture shifts out {0x04, 0x12345678, 0}.
REQ-028 SHALL cover: DMI update while WaitReadValid -> error_q 3; next capture op 3; new ops ignored until dtmcs write 0x00010000 clears it.
REQ-029 SHALL cover: trst_i asserted in Write with ready 0 -> req_valid 0 immediately, state Idle, error_q 0.
REQ-030 SHALL cover: dmi_clear_i pulse same cycle as dmi_resp_valid_i -> Idle, error_q 0, data_q unchanged.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared DMI/DTM field widths, encodings, dtmcs layout and FSM states
package dm_pkg;

   localparam int DmiDataW = 32;
   localparam int DmiOpW   = 2;

   typedef enum logic [1:0] {
      DtmNop   = 2'd0,
      DtmRead  = 2'd1,
      DtmWrite = 2'd2,
      DtmBusy  = 2'd3
   } dtm_op_e;

   localparam int DtmcsDmiReset     = 16;
   localparam int DtmcsDmiHardReset = 17;

   typedef enum logic [2:0] {
      Idle,
      Read,
      WaitReadValid,
      Write,
      WaitWriteValid
   } dmi_state_e;

   // dtmcs capture word: idle hint, sticky status, address width, version 1 (0.13)
   function automatic logic [31:0] dtmcs_word(logic [2:0] idle, logic [1:0] stat, logic [5:0] abits);
      return {14'b0, 1'b0, 1'b0, 1'b0, idle, stat, abits, 4'd1};
   endfunction

endpackage

// File: rtl/dmi_jtag_ctrl_if.sv
// rtl/dmi_jtag_ctrl_if.sv - DMI request/response bus between the DTM and the debug module
interface dmi_jtag_ctrl_if #(parameter int AbitsW = 7);
   import dm_pkg::*;

   logic                dmi_req_valid_o;
   logic                dmi_req_ready_i;
   logic [AbitsW-1:0]   dmi_req_addr_o;
   logic [DmiDataW-1:0] dmi_req_data_o;
   logic [DmiOpW-1:0]   dmi_req_op_o;
   logic                dmi_resp_valid_i;
   logic                dmi_resp_ready_o;
   logic [DmiDataW-1:0] dmi_resp_data_i;
   logic [DmiOpW-1:0]   dmi_resp_resp_i;

   modport master (
      output dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o, dmi_resp_ready_o,
      input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i
   );

   modport slave (
      input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o, dmi_resp_ready_o,
      output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i
   );

endinterface

// File: rtl/dmi_shift_reg.sv
// rtl/dmi_shift_reg.sv - generic JTAG data register: parallel capture, LSB-first shift
module dmi_shift_reg #(
   parameter int Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [Width-1:0] load_data,
   input  logic             tdi,
   output logic [Width-1:0] q
);

   // capture has priority; shifting moves tdi into the MSB and bit 0 out toward tdo
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        q <= '0;
      else if (load)  q <= load_data;
      else if (shift) q <= {tdi, q[Width-1:1]};
   end

endmodule

// File: rtl/dmi_jtag_ctrl.sv
// rtl/dmi_jtag_ctrl.sv - JTAG DTM: dtmcs/dmi data registers and the DMI request FSM
module dmi_jtag_ctrl
   import dm_pkg::*;
#(
   parameter logic [2:0] IdleCycles = 3'd1,
   parameter int         AbitsW     = 7
) (
   input  logic           tck_i,
   input  logic           trst_i,
   input  logic           capture_i,
   input  logic           shift_i,
   input  logic           update_i,
   input  logic           tdi_i,
   input  logic           dmi_clear_i,
   input  logic           dtmcs_select_i,
   input  logic           dmi_select_i,
   output logic           dtmcs_tdo_o,
   output logic           dmi_tdo_o,
   dmi_jtag_ctrl_if.master dmi
);

   localparam int DmiW = AbitsW + 34;

   dmi_state_e          state_q, state_d;
   logic [AbitsW-1:0]   addr_q, addr_d;
   logic [DmiDataW-1:0] data_q, data_d;
   logic [1:0]          error_q, error_d;

   logic [31:0]         dtmcs_q;
   logic [DmiW-1:0]     dmi_q;
   logic [1:0]          dmi_capture_op;
   logic                dtmcs_capture, dtmcs_shift, dtmcs_update;
   logic                dmi_capture, dmi_shift, dmi_update;
   logic                unused_dtmcs;

   assign dtmcs_capture = capture_i & dtmcs_select_i;
   assign dtmcs_shift   = shift_i   & dtmcs_select_i;
   assign dtmcs_update  = update_i  & dtmcs_select_i;
   assign dmi_capture   = capture_i & dmi_select_i;
   assign dmi_shift     = shift_i   & dmi_select_i;
   assign dmi_update    = update_i  & dmi_select_i;

   // a capture during an in-flight access (or with busy still sticky) reports busy
   assign dmi_capture_op = (state_q != Idle || error_q == DtmBusy) ? DtmBusy : error_q;

   dmi_shift_reg #(.Width(32)) u_dtmcs_reg (
      .clk       (tck_i),
      .rst       (trst_i),
      .load      (dtmcs_capture),
      .shift     (dtmcs_shift),
      .load_data (dtmcs_word(IdleCycles, error_q, 6'(AbitsW))),
      .tdi       (tdi_i),
      .q         (dtmcs_q)
   );

   dmi_shift_reg #(.Width(DmiW)) u_dmi_reg (
      .clk       (tck_i),
      .rst       (trst_i),
      .load      (dmi_capture),
      .shift     (dmi_shift),
      .load_data ({addr_q, data_q, dmi_capture_op}),
      .tdi       (tdi_i),
      .q         (dmi_q)
   );

   assign dtmcs_tdo_o  = dtmcs_q[0];
   assign dmi_tdo_o    = dmi_q[0];
   assign unused_dtmcs = ^{dtmcs_q[31:DtmcsDmiHardReset+1], dtmcs_q[DtmcsDmiReset-1:1]};

   assign dmi.dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
   assign dmi.dmi_req_addr_o   = addr_q;
   assign dmi.dmi_req_data_o   = data_q;
   assign dmi.dmi_req_op_o     = (state_q == Read)  ? DtmRead  :
                                 (state_q == Write) ? DtmWrite : DtmNop;
   assign dmi.dmi_resp_ready_o = 1'b1;

   // next-state: launch on update, hand off on ready, retire on response; clears override all
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      error_d = error_q;

      case (state_q)
         Idle: begin
            if (dmi_update && error_q == DtmNop) begin
               if (dmi_q[1:0] == DtmRead) begin
                  addr_d  = dmi_q[DmiW-1:34];
                  state_d = Read;
               end else if (dmi_q[1:0] == DtmWrite) begin
                  addr_d  = dmi_q[DmiW-1:34];
                  data_d  = dmi_q[33:2];
                  state_d = Write;
               end
            end
         end
         Read:  if (dmi.dmi_req_ready_i) state_d = WaitReadValid;
         Write: if (dmi.dmi_req_ready_i) state_d = WaitWriteValid;
         WaitReadValid: begin
            if (dmi.dmi_resp_valid_i) begin
               data_d = dmi.dmi_resp_data_i;
               if (dmi.dmi_resp_resp_i != DtmNop) error_d = dmi.dmi_resp_resp_i;
               state_d = Idle;
            end
         end
         WaitWriteValid: begin
            if (dmi.dmi_resp_valid_i) begin
               if (dmi.dmi_resp_resp_i != DtmNop) error_d = dmi.dmi_resp_resp_i;
               state_d = Idle;
            end
         end
         default: state_d = Idle;
      endcase

      // registered state decides busy, so a response in the same cycle does not hide it
      if ((dmi_capture || dmi_update) && state_q != Idle) error_d = DtmBusy;

      if (dtmcs_update && dtmcs_q[DtmcsDmiReset]) error_d = DtmNop;

      if ((dtmcs_update && dtmcs_q[DtmcsDmiHardReset]) || dmi_clear_i) begin
         state_d = Idle;
         error_d = DtmNop;
         addr_d  = addr_q;
         data_d  = data_q;
      end
   end

   // state and latched request/response fields
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         state_q <= Idle;
         addr_q  <= '0;
         data_q  <= '0;
         error_q <= DtmNop;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_dmi_jtag_ctrl.sv
// tb/tb_dmi_jtag_ctrl.sv - scoreboard bench for dmi_jtag_ctrl
module tb_dmi_jtag_ctrl;

   localparam int AW = 7;

   logic tck = 1'b0;
   logic trst = 1'b1;
   logic capture = 1'b0, shift = 1'b0, update = 1'b0, tdi = 1'b0;
   logic dmi_clear = 1'b0, dtmcs_sel = 1'b0, dmi_sel = 1'b0;
   logic dtmcs_tdo, dmi_tdo;

   always #5 tck = ~tck;

   dmi_jtag_ctrl_if #(.AbitsW(AW)) dmi_bus ();

   dmi_jtag_ctrl #(.IdleCycles(3'd1), .AbitsW(AW)) dut (
      .tck_i          (tck),
      .trst_i         (trst),
      .capture_i      (capture),
      .shift_i        (shift),
      .update_i       (update),
      .tdi_i          (tdi),
      .dmi_clear_i    (dmi_clear),
      .dtmcs_select_i (dtmcs_sel),
      .dmi_select_i   (dmi_sel),
      .dtmcs_tdo_o    (dtmcs_tdo),
      .dmi_tdo_o      (dmi_tdo),
      .dmi            (dmi_bus)
   );

   // debug-module side: automatic responder or manual drive
   bit          auto_resp = 1'b1;
   int          resp_delay = 1;
   logic [31:0] resp_data = 32'h0;
   logic [1:0]  resp_code = 2'd0;
   logic        auto_ready = 1'b0, auto_rvalid = 1'b0;
   logic [31:0] auto_rdata = 32'h0;
   logic [1:0]  auto_rresp = 2'd0;
   logic        man_ready = 1'b0, man_rvalid = 1'b0;
   logic [31:0] man_rdata = 32'h0;
   logic [1:0]  man_rresp = 2'd0;

   assign dmi_bus.dmi_req_ready_i  = auto_ready | man_ready;
   assign dmi_bus.dmi_resp_valid_i = auto_rvalid | man_rvalid;
   assign dmi_bus.dmi_resp_data_i  = auto_resp ? auto_rdata : man_rdata;
   assign dmi_bus.dmi_resp_resp_i  = auto_resp ? auto_rresp : man_rresp;

   // scoreboard
   int          total = 0;
   int          bad = 0;
   string       exp_name[$];
   logic [63:0] exp_val[$];
   logic [63:0] act_val[$];
   logic [40:0] exp_req[$];

   function automatic logic [63:0] dv(logic [6:0] a, logic [31:0] d, logic [1:0] o);
      return {23'b0, a, d, o};
   endfunction

   task automatic probe(input string n, input logic [63:0] e, input logic [63:0] a);
      exp_name.push_back(n);
      exp_val.push_back(e);
      act_val.push_back(a);
   endtask

   task automatic scan(input bit is_dmi, input int w, input logic [63:0] din,
                       input bit do_update, input string n, input logic [63:0] e);
      logic [63:0] dout;
      dout = '0;
      exp_name.push_back(n);
      exp_val.push_back(e);
      @(negedge tck);
      capture = 1'b1; shift = 1'b0; dtmcs_sel = !is_dmi; dmi_sel = is_dmi;
      for (int i = 0; i < w; i++) begin
         @(negedge tck);
         capture = 1'b0; shift = 1'b1; tdi = din[i];
         #1 dout[i] = is_dmi ? dmi_tdo : dtmcs_tdo;
      end
      @(negedge tck);
      shift = 1'b0; tdi = 1'b0; update = do_update;
      @(negedge tck);
      update = 1'b0; dtmcs_sel = 1'b0; dmi_sel = 1'b0;
      act_val.push_back(dout);
   endtask

   // monitor: request handshakes against expected requests, scan/probe results in order
   initial begin
      forever begin
         @(negedge tck);
         #2;
         if (dmi_bus.dmi_req_valid_o && dmi_bus.dmi_req_ready_i) begin
            logic [40:0] got, want;
            got = {dmi_bus.dmi_req_addr_o, dmi_bus.dmi_req_data_o, dmi_bus.dmi_req_op_o};
            total++;
            if (exp_req.size() == 0) begin
               bad++;
               $display("FAIL req_unexpected: got %h want none", got);
            end else begin
               want = exp_req.pop_front();
               if (got !== want) begin
                  bad++;
                  $display("FAIL req_fields: got %h want %h", got, want);
               end
            end
         end
         while (act_val.size() > 0 && exp_val.size() > 0) begin
            string       n;
            logic [63:0] a, e;
            n = exp_name.pop_front();
            e = exp_val.pop_front();
            a = act_val.pop_front();
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL %s: got %h want %h", n, a, e);
            end
         end
      end
   end

   // responder: ready one cycle after valid, response resp_delay cycles after handshake
   initial begin
      forever begin
         @(negedge tck);
         if (auto_resp && dmi_bus.dmi_req_valid_o && !trst) begin
            @(negedge tck);
            auto_ready = 1'b1;
            @(negedge tck);
            auto_ready = 1'b0;
            repeat (resp_delay - 1) @(negedge tck);
            auto_rvalid = 1'b1; auto_rdata = resp_data; auto_rresp = resp_code;
            @(negedge tck);
            auto_rvalid = 1'b0;
         end
      end
   end

   // stimulus
   initial begin
      repeat (2) @(negedge tck);
      #1;
      probe("rst_req_valid", 64'd0, {63'd0, dmi_bus.dmi_req_valid_o});
      probe("rst_dtmcs_tdo", 64'd0, {63'd0, dtmcs_tdo});
      probe("rst_dmi_tdo", 64'd0, {63'd0, dmi_tdo});
      probe("resp_ready", 64'd1, {63'd0, dmi_bus.dmi_resp_ready_o});
      @(negedge tck);
      trst = 1'b0;

      scan(1'b0, 32, 64'd0, 1'b0, "dtmcs_reset", 64'h1071);
      scan(1'b1, AW + 34, 64'd0, 1'b0, "dmi_reset", 64'd0);

      // write 0x10 <- 0xDEADBEEF
      exp_req.push_back({7'h10, 32'hDEADBEEF, 2'd2});
      scan(1'b1, AW + 34, dv(7'h10, 32'hDEADBEEF, 2'd2), 1'b1, "wr_launch", 64'd0);
      repeat (6) @(negedge tck);
      scan(1'b1, AW + 34, 64'd0, 1'b1, "wr_done", dv(7'h10, 32'hDEADBEEF, 2'd0));

      // read 0x04 -> 0x12345678
      resp_data = 32'h12345678; resp_code = 2'd0;
      exp_req.push_back({7'h04, 32'hDEADBEEF, 2'd1});
      scan(1'b1, AW + 34, dv(7'h04, 32'h0, 2'd1), 1'b1, "rd_launch", dv(7'h10, 32'hDEADBEEF, 2'd0));
      repeat (6) @(negedge tck);
      scan(1'b1, AW + 34, 64'd0, 1'b1, "rd_data", dv(7'h04, 32'h12345678, 2'd0));

      // update while waiting for a slow read response -> sticky busy
      resp_delay = 30; resp_data = 32'hCAFEF00D;
      exp_req.push_back({7'h08, 32'h12345678, 2'd1});
      scan(1'b1, AW + 34, dv(7'h08, 32'h0, 2'd1), 1'b1, "busy_launch", dv(7'h04, 32'h12345678, 2'd0));
      repeat (3) @(negedge tck);
      dmi_sel = 1'b1; update = 1'b1;
      @(negedge tck);
      dmi_sel = 1'b0; update = 1'b0;
      repeat (35) @(negedge tck);
      scan(1'b1, AW + 34, dv(7'h20, 32'h11111111, 2'd2), 1'b1, "busy_sticky", dv(7'h08, 32'hCAFEF00D, 2'd3));
      repeat (6) @(negedge tck);
      scan(1'b0, 32, 64'h00010000, 1'b1, "dtmcs_busy", 64'h1C71);
      scan(1'b0, 32, 64'd0, 1'b0, "dtmcs_cleared", 64'h1071);
      resp_delay = 1; resp_data = 32'h55555555;
      exp_req.push_back({7'h20, 32'h11111111, 2'd2});
      scan(1'b1, AW + 34, dv(7'h20, 32'h11111111, 2'd2), 1'b1, "after_clear", dv(7'h08, 32'hCAFEF00D, 2'd0));
      repeat (6) @(negedge tck);

      // reset in Write with ready held low
      auto_resp = 1'b0;
      scan(1'b1, AW + 34, dv(7'h30, 32'hA5A5A5A5, 2'd2), 1'b1, "wr_hold", dv(7'h20, 32'h11111111, 2'd0));
      #1 probe("wr_valid", 64'd1, {63'd0, dmi_bus.dmi_req_valid_o});
      @(negedge tck);
      trst = 1'b1;
      #1 probe("trst_valid", 64'd0, {63'd0, dmi_bus.dmi_req_valid_o});
      @(negedge tck);
      trst = 1'b0;
      scan(1'b0, 32, 64'd0, 1'b0, "trst_dtmcs", 64'h1071);
      @(negedge tck);
      man_rvalid = 1'b1; man_rdata = 32'hBAD00BAD; man_rresp = 2'd2;
      @(negedge tck);
      man_rvalid = 1'b0;
      scan(1'b1, AW + 34, 64'd0, 1'b1, "late_resp", 64'd0);

      // dmi_clear in the same cycle as a read response
      exp_req.push_back({7'h0C, 32'h0, 2'd1});
      scan(1'b1, AW + 34, dv(7'h0C, 32'h0, 2'd1), 1'b1, "clr_launch", 64'd0);
      man_ready = 1'b1;
      @(negedge tck);
      man_ready = 1'b0;
      man_rvalid = 1'b1; man_rdata = 32'h77777777; man_rresp = 2'd2; dmi_clear = 1'b1;
      @(negedge tck);
      man_rvalid = 1'b0; dmi_clear = 1'b0;
      scan(1'b1, AW + 34, 64'd0, 1'b0, "clr_resp", dv(7'h0C, 32'h0, 2'd0));
      scan(1'b0, 32, 64'd0, 1'b0, "clr_dtmcs", 64'h1071);

      repeat (5) @(negedge tck);
      probe("req_pending", 64'd0, 64'(exp_req.size()));
      for (int k = 0; k < 20 && exp_val.size() > 0; k++) @(negedge tck);
      if (exp_val.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_val.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
